// File: rtl/ucsbece154a_mem_wait.sv
// ucsbece154a_mem_wait
// Unified instruction/data memory for the multicycle RISC-V core, with a
// programmable number of wait states between request acceptance and access.
//
// Ports:
//   clk          core clock, all state updates on the rising edge
//   reset        asynchronous active-low reset (array contents not reset)
//   a_i          byte address
//   wd_i         write data
//   we_i         write request (takes priority over re_i)
//   re_i         read request
//   be_i         byte-lane write enables (only with UCSBECE154A_MEM_BYTE_EN)
//   rd_o         registered read data
//   ready_o      one-cycle access-complete pulse
//   stall_o      request pending and not yet complete
//   misaligned_o pulses with ready_o when the accepted address was misaligned
//   err_sticky_o set by any misaligned or out-of-range access, cleared by reset
//
// Optional feature macro: UCSBECE154A_MEM_BYTE_EN (adds be_i byte-lane writes).
module ucsbece154a_mem_wait #(
  parameter int unsigned WORDS     = 64,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a_i,
  input  logic [31:0] wd_i,
  input  logic        we_i,
  input  logic        re_i,
`ifdef UCSBECE154A_MEM_BYTE_EN
  input  logic [3:0]  be_i,
`endif
  output logic [31:0] rd_o,
  output logic        ready_o,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        err_sticky_o
);

  localparam int unsigned IdxW      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [32:0] SpanBytes = 33'(WORDS) * 33'd4;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wd;
  logic        r_we;
  logic [31:0] r_rd;
  logic        r_mis;
  logic        r_err;
`ifdef UCSBECE154A_MEM_BYTE_EN
  logic [3:0]  r_be;
`endif

  logic [31:0] r_mem [WORDS];

  logic            w_req;
  logic [31:0]     w_off;
  logic            w_in_range;
  logic [IdxW-1:0] w_idx;
  logic            w_mis;
  logic            w_access;
  logic            w_bad;

  assign w_req = re_i | we_i;

  // Offset is only meaningful when r_addr >= ADDR_BASE; the explicit compare
  // rules out wrap-around of the subtraction.
  assign w_off      = r_addr - ADDR_BASE;
  assign w_in_range = (r_addr >= ADDR_BASE) && ({1'b0, w_off} < SpanBytes);
  assign w_idx      = w_off[IdxW+1:2];

`ifdef UCSBECE154A_MEM_BYTE_EN
  // Sub-word accesses select lanes of the addressed word directly, so only a
  // full-word access can straddle a word boundary.
  assign w_mis = (r_be == 4'hF) && (r_addr[1:0] != 2'b00);
`else
  assign w_mis = (r_addr[1:0] != 2'b00);
`endif

  assign w_bad    = w_mis | ~w_in_range;
  assign w_access = (r_state == StBusy) && (r_cnt == 4'd0);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_req) w_state_nxt = StBusy;
      StBusy:  if (r_cnt == 4'd0) w_state_nxt = StResp;
      StResp:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_wd    <= 32'd0;
      r_we    <= 1'b0;
      r_rd    <= 32'd0;
      r_mis   <= 1'b0;
      r_err   <= 1'b0;
`ifdef UCSBECE154A_MEM_BYTE_EN
      r_be    <= 4'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        StIdle: begin
          if (w_req) begin
            r_addr <= a_i;
            r_wd   <= wd_i;
            r_we   <= we_i;
            r_cnt  <= 4'(LATENCY);
`ifdef UCSBECE154A_MEM_BYTE_EN
            r_be   <= be_i;
`endif
          end
        end
        StBusy: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            // Writes leave rd_o untouched; bad reads return zero.
            if (!r_we) r_rd <= w_bad ? 32'd0 : r_mem[w_idx];
            r_mis <= w_mis;
            if (w_bad) r_err <= 1'b1;
          end
        end
        StResp:  r_mis <= 1'b0;
        default: ;
      endcase
    end
  end

  // Array is not reset; a reset mid-access forces StIdle so w_access drops.
  always_ff @(posedge clk) begin
    if (w_access && r_we && !w_bad) begin
`ifdef UCSBECE154A_MEM_BYTE_EN
      for (int k = 0; k < 4; k++) begin
        if (r_be[k]) r_mem[w_idx][8*k +: 8] <= r_wd[8*k +: 8];
      end
`else
      r_mem[w_idx] <= r_wd;
`endif
    end
  end

  assign rd_o         = r_rd;
  assign ready_o      = (r_state == StResp);
  assign stall_o      = (r_state == StBusy) | ((r_state == StIdle) & w_req);
  assign misaligned_o = r_mis;
  assign err_sticky_o = r_err;

endmodule

// File: tb/tb_ucsbece154a_mem_wait.sv
// Directed bench for ucsbece154a_mem_wait: one instance with LATENCY=2 and one
// with LATENCY=0, sharing clock, reset, address and write data.
module tb_ucsbece154a_mem_wait;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a_i, wd_i;
  logic        we0, re0, we1, re1;
  logic [31:0] rd0, rd1;
  logic        ready0, ready1, stall0, stall1, mis0, mis1, err0, err1;
`ifdef UCSBECE154A_MEM_BYTE_EN
  logic [3:0]  be_i;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Muxed view of the instance under test.
  bit          cur_sel;
  logic [31:0] g_rd;
  logic        g_ready, g_stall, g_mis, g_err;
  assign g_rd    = cur_sel ? rd1    : rd0;
  assign g_ready = cur_sel ? ready1 : ready0;
  assign g_stall = cur_sel ? stall1 : stall0;
  assign g_mis   = cur_sel ? mis1   : mis0;
  assign g_err   = cur_sel ? err1   : err0;

  // Results of the last mem_op.
  logic [31:0] op_rd;
  logic        op_mis;
  int          op_busy;

  always #5 clk = ~clk;

  ucsbece154a_mem_wait #(.WORDS(64), .ADDR_BASE(32'h0), .LATENCY(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .a_i          (a_i),
    .wd_i         (wd_i),
    .we_i         (we0),
    .re_i         (re0),
`ifdef UCSBECE154A_MEM_BYTE_EN
    .be_i         (be_i),
`endif
    .rd_o         (rd0),
    .ready_o      (ready0),
    .stall_o      (stall0),
    .misaligned_o (mis0),
    .err_sticky_o (err0)
  );

  ucsbece154a_mem_wait #(.WORDS(64), .ADDR_BASE(32'h0), .LATENCY(0)) dut0 (
    .clk          (clk),
    .reset        (reset),
    .a_i          (a_i),
    .wd_i         (wd_i),
    .we_i         (we1),
    .re_i         (re1),
`ifdef UCSBECE154A_MEM_BYTE_EN
    .be_i         (be_i),
`endif
    .rd_o         (rd1),
    .ready_o      (ready1),
    .stall_o      (stall1),
    .misaligned_o (mis1),
    .err_sticky_o (err1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input bit we, input bit re);
    if (cur_sel) begin
      we1 = we; re1 = re;
    end else begin
      we0 = we; re0 = re;
    end
  endtask

  // One request: drive at a negedge, accept at the next posedge, then count
  // non-ready cycles until the ready pulse. perturb scrambles a_i/wd_i after
  // acceptance to show the latched values are used.
  task automatic mem_op(input bit sel, input bit we, input bit re, input logic [31:0] a,
                        input logic [31:0] wd, input bit perturb);
    int stall_lo;
    cur_sel = sel;
    stall_lo = 0;
    @(negedge clk);
    a_i = a; wd_i = wd;
    set_req(we, re);
    #1 check_eq("stall_at_request", {31'd0, g_stall}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (perturb) begin
      a_i = 32'h3C; wd_i = ~wd;
    end else begin
      set_req(1'b0, 1'b0);
    end
    op_busy = 0;
    #1;
    while (!g_ready && op_busy < 40) begin
      if (!g_stall) stall_lo++;
      op_busy++;
      @(negedge clk);
      #1;
    end
    if (!g_ready) begin
      check_eq("ready_timeout", 32'd0, 32'd1);
    end else begin
      op_rd  = g_rd;
      op_mis = g_mis;
      check_eq("stall_low_in_resp", {31'd0, g_stall}, 32'd0);
      check_eq("stall_during_busy_lows", stall_lo, 32'd0);
      set_req(1'b0, 1'b0);
      @(negedge clk);
      #1 check_eq("ready_single_pulse", {31'd0, g_ready}, 32'd0);
      check_eq("mis_cleared_after_resp", {31'd0, g_mis}, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b0;
    a_i = 32'd0; wd_i = 32'd0;
    we0 = 1'b0; re0 = 1'b0; we1 = 1'b0; re1 = 1'b0;
`ifdef UCSBECE154A_MEM_BYTE_EN
    be_i = 4'hF;
`endif
    cur_sel = 1'b0;
    #12;
    check_eq("rst_rd", rd0, 32'd0);
    check_eq("rst_ready", {31'd0, ready0}, 32'd0);
    check_eq("rst_mis", {31'd0, mis0}, 32'd0);
    check_eq("rst_err", {31'd0, err0}, 32'd0);
    check_eq("rst_stall", {31'd0, stall0}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Latency 2: write then read 0x8; ready comes 3 busy cycles after acceptance.
    mem_op(1'b0, 1'b1, 1'b0, 32'h8, 32'hDEADBEEF, 1'b0);
    check_eq("wr8_busy_cycles", op_busy, 32'd3);
    check_eq("wr8_mis", {31'd0, op_mis}, 32'd0);
    check_eq("wr8_rd_unchanged", op_rd, 32'd0);
    mem_op(1'b0, 1'b0, 1'b1, 32'h8, 32'h0, 1'b0);
    check_eq("rd8_busy_cycles", op_busy, 32'd3);
    check_eq("rd8_data", op_rd, 32'hDEADBEEF);

    // we&re together is a write; inputs scrambled during BUSY are ignored.
    mem_op(1'b0, 1'b1, 1'b1, 32'h10, 32'h12345678, 1'b1);
    check_eq("simul_rd_unchanged", op_rd, 32'hDEADBEEF);
    mem_op(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0);
    check_eq("simul_mem4", op_rd, 32'h12345678);

    // Misaligned read.
    mem_op(1'b0, 1'b1, 1'b0, 32'h0, 32'h11111111, 1'b0);
    check_eq("err_before_bad", {31'd0, err0}, 32'd0);
    mem_op(1'b0, 1'b0, 1'b1, 32'h6, 32'h0, 1'b0);
    check_eq("mis6_flag", {31'd0, op_mis}, 32'd1);
    check_eq("mis6_rd", op_rd, 32'd0);
    check_eq("mis6_err", {31'd0, err0}, 32'd1);
    mem_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    check_eq("rd0_after_mis", op_rd, 32'h11111111);
    check_eq("rd0_mis_clear", {31'd0, op_mis}, 32'd0);
    check_eq("err_sticky_holds", {31'd0, err0}, 32'd1);

    // Out-of-range write at 4*WORDS must not alias onto mem[0].
    mem_op(1'b0, 1'b1, 1'b0, 32'h100, 32'hBAD0BAD0, 1'b0);
    check_eq("oor_wr_mis", {31'd0, op_mis}, 32'd0);
    check_eq("oor_wr_rd_unchanged", op_rd, 32'h11111111);
    mem_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    check_eq("oor_mem0_kept", op_rd, 32'h11111111);
    mem_op(1'b0, 1'b0, 1'b1, 32'h100, 32'h0, 1'b0);
    check_eq("oor_rd_zero", op_rd, 32'd0);
    check_eq("oor_rd_mis", {31'd0, op_mis}, 32'd0);
    mem_op(1'b0, 1'b0, 1'b1, 32'hFC, 32'h0, 1'b0);
    check_eq("last_word_mis", {31'd0, op_mis}, 32'd0);

    // Reset one cycle into BUSY of a write to mem[2].
    cur_sel = 1'b0;
    @(negedge clk);
    a_i = 32'h8; wd_i = 32'hCAFEF00D; we0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    we0 = 1'b0;
    #1 check_eq("abort_in_busy", {31'd0, stall0}, 32'd1);
    reset = 1'b0;
    #1;
    check_eq("abort_ready", {31'd0, ready0}, 32'd0);
    check_eq("abort_idle_stall", {31'd0, stall0}, 32'd0);
    check_eq("abort_err_cleared", {31'd0, err0}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 check_eq("abort_no_ready", {31'd0, ready0}, 32'd0);
    end
    mem_op(1'b0, 1'b0, 1'b1, 32'h8, 32'h0, 1'b0);
    check_eq("abort_mem2_kept", op_rd, 32'hDEADBEEF);
    check_eq("abort_err_still0", {31'd0, err0}, 32'd0);

    // Latency 0 instance.
    mem_op(1'b1, 1'b1, 1'b0, 32'h0, 32'h00500093, 1'b0);
    check_eq("l0_wr_busy_cycles", op_busy, 32'd1);
    mem_op(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    check_eq("l0_rd_busy_cycles", op_busy, 32'd1);
    check_eq("l0_rd_data", op_rd, 32'h00500093);

`ifdef UCSBECE154A_MEM_BYTE_EN
    mem_op(1'b0, 1'b1, 1'b0, 32'h4, 32'hAABBCCDD, 1'b0);
    be_i = 4'b0010;
    mem_op(1'b0, 1'b1, 1'b0, 32'h4, 32'h0000EE00, 1'b0);
    be_i = 4'hF;
    mem_op(1'b0, 1'b0, 1'b1, 32'h4, 32'h0, 1'b0);
    check_eq("be_lane1", op_rd, 32'hAABBEEDD);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ucsbece154a_mem_wait.md
Name: ucsbece154a_mem_wait

Overview:
- Unified instruction/data memory for the multicycle RISC-V core, with a configurable wait-state model.
- Sits directly downstream of the main-FSM controller and datapath. It consumes the memory address (PC or ALUOut, selected by AdrSrc), WriteData and MemWrite.
- Returns ReadData for the instruction and data registers, plus a stall indication the controller uses to hold its FSM state.
- Lets the team exercise the core against non-zero-latency memory.

Parameters:
- WORDS, 64: number of 32-bit words in the internal array.
- ADDR_BASE, 32'h0000_0000: byte address of word 0.
- LATENCY, 2: wait cycles between acceptance and access (0..15).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- a_i  input  32  byte address.
- wd_i  input  32  write data.
- we_i  input  1  write request (controller MemWrite).
- re_i  input  1  read request (fetch or MemRead state).
- rd_o  output  32  registered read data.
- ready_o  output  1  one-cycle access-complete pulse.
- stall_o  output  1  request pending, not yet complete.
- misaligned_o  output  1  pulses with ready_o when the access had a[1:0] != 0.
- err_sticky_o  output  1  set on any misaligned or out-of-range access; cleared only by reset.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, cnt=0, rd_o=0, ready_o=0, misaligned_o=0, err_sticky_o=0. Array contents are not reset.
- FSM states:
  - IDLE: accepts a request when (re_i|we_i). It latches a_i, wd_i and op (write if we_i, else read), loads cnt=LATENCY, and goes to BUSY.
  - BUSY: on each edge with cnt!=0, decrement cnt. On the edge with cnt==0, perform the access and go to RESP.
  - RESP: ready_o=1 for exactly this cycle; next edge returns to IDLE. A new request is not accepted in RESP.
- Timing: a request sampled at edge t0 gives ready_o high in the cycle after edge t0+LATENCY+1. With LATENCY=0, ready_o is high in the cycle after t0+1.
- Outputs:
  - stall_o = (state==BUSY) | (state==IDLE & (re_i|we_i)). It is combinational and low in RESP.
  - ready_o = (state==RESP), decoded from registered state.
- Addressing:
  - Word index = (a - ADDR_BASE) >> 2.
  - In range when ADDR_BASE <= a < ADDR_BASE + 4*WORDS. The subtraction is a 32-bit unsigned compare, with no wrap-around past 2^32.
- Read: rd_o <= mem[index] at the access edge. Out of range gives rd_o <= 0.
- Write: mem[index] <= wd latched at acceptance. Out of range writes are dropped and rd_o is unchanged.
- Misaligned (latched a[1:0] != 0):
  - No array access; reads return rd_o <= 0.
  - misaligned_o=1 during RESP; err_sticky_o set.
- Out of range: err_sticky_o set; misaligned_o not asserted.
- Simultaneous we_i & re_i: treated as a write.
- Input changes after acceptance are ignored until the next IDLE.
- Reset during BUSY or RESP aborts the operation: no write occurs, ready_o is not pulsed, and state returns to IDLE.

Optional Feature:
- Macro: UCSBECE154A_MEM_BYTE_EN
- Defined:
  - Adds input be_i [3:0], latched at acceptance.
  - Writes update only the byte lanes with be_i[k]=1 (lane k = bits 8k+7:8k).
  - Misalignment is checked per access as a[1:0] != 0 only when be_i==4'b1111. Sub-word accesses may be unaligned within a word, but lanes must not cross the word.
  - Reads ignore be_i and return the full word.
- Not defined: no be_i port; every write is a full 32-bit word.

Test Plan:
- Latency check: LATENCY=2, write wd=32'hDEADBEEF to a=32'h8 at t0, then read a=32'h8 → ready_o high only in cycle t0+3, rd_o=32'hDEADBEEF, stall_o high cycles t0..t0+2.
- LATENCY=0: read a=0 after preload mem[0]=32'h00500093 → ready_o in cycle after t0+1, rd_o=32'h00500093.
- Bad accesses:
  - Read a=32'h6 → misaligned_o=1 with ready_o, rd_o=0, err_sticky_o=1 and stays 1.
  - Write a=4*WORDS (out of range) → array unchanged, misaligned_o=0.
- Simultaneous requests and input hold: we_i=re_i=1, a=32'h10, wd=32'h12345678 → mem[4]=32'h12345678. Changing a_i during BUSY does not alter the target.
- Reset mid-write: reset=0 one cycle into BUSY of a write to mem[2] → ready_o never pulses, mem[2] keeps its old value, state IDLE; err_sticky_o=0.
- With UCSBECE154A_MEM_BYTE_EN: mem[1]=32'hAABBCCDD, write a=32'h4, be_i=4'b0010, wd=32'h0000EE00 → read returns 32'hAABBEEDD.
